// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and runs a request/ready handshake with
// instruction memory, presenting instr_IF/pc_IF combinationally to IF/ID.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [3:0]  HALT_OPC  = 4'hF,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_IF,
    output logic [15:0] pc_IF,
    output logic        if_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc_q, hold_pc_d;
    logic [15:0] addr_inc_s;

    function automatic logic is_halt(input logic [15:0] instr);
        is_halt = (instr[15:12] == HALT_OPC);
    endfunction

    assign addr_inc_s = addr_q + 16'd1;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            hold_instr_q <= 16'h0000;
            hold_pc_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Next-state and output decode; a redirect always suppresses presentation.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        imem_req     = 1'b0;
        imem_addr    = addr_q;
        instr_IF     = NOP_INSTR;
        pc_IF        = 16'h0000;
        if_valid     = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d = branch_target;
                    if (imem_rdy) begin
                        addr_d  = branch_target;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem_rdy) begin
                    instr_IF = imem_rdata;
                    pc_IF    = addr_inc_s;
                    if_valid = 1'b1;
                    pc_d     = addr_inc_s;
                    addr_d   = addr_inc_s;
                    if (stall) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = addr_inc_s;
                        state_d      = ST_HOLD;
                    end else if (is_halt(imem_rdata)) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    addr_d  = branch_target;
                    state_d = ST_FETCH;
                end else begin
                    instr_IF = hold_instr_q;
                    pc_IF    = hold_pc_q;
                    if_valid = 1'b1;
                    if (stall) begin
                        state_d = ST_HOLD;
                    end else if (is_halt(hold_instr_q)) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            // The abandoned access must complete at its original address before refetching.
            ST_DRAIN: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = ST_DRAIN;
                end else if (imem_rdy) begin
                    addr_d  = pc_q;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
                if (branch_taken) begin
                    pc_d    = branch_target;
                    addr_d  = branch_target;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end

            default: begin
                state_d = ST_FETCH;
                pc_d    = RESET_PC;
                addr_d  = RESET_PC;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a behavioural memory with adjustable
// latency, a scoreboard of expected presentations and per-cycle handshake checks.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_rdata;
    logic [15:0] instr_IF;
    logic [15:0] pc_IF;
    logic        if_valid;
    logic        halted;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_cnt = 0;
    int          lat      = 1;
    bit          hold_off = 1'b1;
    bit          mon_en   = 1'b0;
    logic [31:0] exp_q[$];

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdy      (imem_rdy),
        .imem_rdata    (imem_rdata),
        .instr_IF      (instr_IF),
        .pc_IF         (pc_IF),
        .if_valid      (if_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0005: mem_word = 16'h1234;
            16'h0042: mem_word = 16'hF000;
            default:  mem_word = {4'h0, a[11:0]};
        endcase
    endfunction

    // Memory model: rdy after lat cycles of a steady request, none while hold_off.
    assign imem_rdy   = imem_req && !hold_off && (wait_cnt >= lat - 1);
    assign imem_rdata = imem_rdy ? mem_word(imem_addr) : 16'hDEAD;

    always @(posedge clk) begin
        if (rst || hold_off || !imem_req || imem_rdy) wait_cnt <= 0;
        else                                          wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] ins, input logic [15:0] pc);
        exp_q.push_back({ins, pc});
    endtask

    // Scoreboard: every presented instruction must match the next expected entry.
    always @(negedge clk) begin
        if (mon_en && if_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_valid", {16'h0000, instr_IF}, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check_eq("sb_instr", {16'h0000, instr_IF}, {16'h0000, e[31:16]});
                check_eq("sb_pc",    {16'h0000, pc_IF},    {16'h0000, e[15:0]});
            end
        end
    end

    task automatic chk_fetch(input string tag, input logic [15:0] addr, input logic valid);
        @(negedge clk);
        check_eq({tag, "_req"},   {31'd0, imem_req}, 32'd1);
        check_eq({tag, "_addr"},  {16'd0, imem_addr}, {16'd0, addr});
        check_eq({tag, "_valid"}, {31'd0, if_valid}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state: requesting RESET_PC, nothing presented.
        chk_fetch("rst", 16'h0000, 1'b0);
        check_eq("rst_instr",  {16'd0, instr_IF}, 32'h0000_0000);
        check_eq("rst_pc",     {16'd0, pc_IF},    32'h0000_0000);
        check_eq("rst_halted", {31'd0, halted},   32'd0);
        step();

        // Zero-wait memory, one instruction per cycle.
        hold_off = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(16'(i), 16'(i + 1));
            chk_fetch("zw", 16'(i), 1'b1);
            step();
        end

        // Two-cycle memory latency at address 4.
        hold_off = 1'b1;
        chk_fetch("lat_idle", 16'h0004, 1'b0);
        step();
        hold_off = 1'b0; lat = 2;
        chk_fetch("lat_c1", 16'h0004, 1'b0);
        step();
        push(16'h0004, 16'h0005);
        chk_fetch("lat_c2", 16'h0004, 1'b1);
        step();
        chk_fetch("lat_next", 16'h0005, 1'b0);
        step();

        // Stalled delivery of 16'h1234 at addr 5, held for three HOLD cycles.
        stall = 1'b1;
        push(16'h1234, 16'h0006);
        chk_fetch("stall_dlv", 16'h0005, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) stall = 1'b0;
            push(16'h1234, 16'h0006);
            @(negedge clk);
            check_eq("hold_req",   {31'd0, imem_req}, 32'd0);
            check_eq("hold_valid", {31'd0, if_valid}, 32'd1);
            step();
        end
        lat = 1;
        push(16'h0006, 16'h0007);
        chk_fetch("hold_resume", 16'h0006, 1'b1);
        step();

        // Branch while addr 7 is outstanding: drain the old access, then fetch target.
        hold_off = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
        chk_fetch("br_out", 16'h0007, 1'b0);
        step();
        branch_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk_fetch("drain_wait", 16'h0007, 1'b0);
            step();
        end
        hold_off = 1'b0;
        chk_fetch("drain_rdy", 16'h0007, 1'b0);
        step();
        push(16'h0040, 16'h0041);
        chk_fetch("br_tgt", 16'h0040, 1'b1);
        step();
        push(16'h0041, 16'h0042);
        chk_fetch("br_tgt1", 16'h0041, 1'b1);
        step();

        // HLT fetched: presented once, then halted with no requests.
        push(16'hF000, 16'h0043);
        chk_fetch("hlt_dlv", 16'h0042, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("halt_flag",  {31'd0, halted},   32'd1);
            check_eq("halt_req",   {31'd0, imem_req}, 32'd0);
            check_eq("halt_valid", {31'd0, if_valid}, 32'd0);
            step();
        end
        branch_taken = 1'b1; branch_target = 16'h0010;
        @(negedge clk);
        check_eq("halt_br_flag", {31'd0, halted}, 32'd1);
        check_eq("halt_br_req",  {31'd0, imem_req}, 32'd0);
        step();
        branch_taken = 1'b0;

        // Resume at 0x10 with a stall, then reset while in HOLD.
        stall = 1'b1;
        push(16'h0010, 16'h0011);
        chk_fetch("resume", 16'h0010, 1'b1);
        check_eq("resume_halted", {31'd0, halted}, 32'd0);
        step();
        rst = 1'b1;
        push(16'h0010, 16'h0011);
        @(negedge clk);
        check_eq("hold_rst_req", {31'd0, imem_req}, 32'd0);
        step();
        rst = 1'b0; hold_off = 1'b1;
        chk_fetch("post_rst", 16'h0000, 1'b0);
        check_eq("post_rst_halted", {31'd0, halted}, 32'd0);
        step();
        stall = 1'b0;

        // Branch coincident with a completing access, then PC wrap at 16'hFFFF.
        hold_off = 1'b0; branch_taken = 1'b1; branch_target = 16'hFFFF;
        chk_fetch("br_rdy", 16'h0000, 1'b0);
        step();
        branch_taken = 1'b0;
        push(16'h0FFF, 16'h0000);
        chk_fetch("wrap", 16'hFFFF, 1'b1);
        step();
        hold_off = 1'b1;
        chk_fetch("wrap_next", 16'h0000, 1'b0);
        step();

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
